pp_accumulator: RTL and testbench

PP_ACCUMULATOR -- requirements
Module: pp_accumulator

---
 rtl/pp_accumulator.sv | 99 +++++++++
 tb/tb_pp_accumulator.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pp_accumulator.sv
// Booth partial-product accumulator: sums 4 sign-extended, weighted partial products (PP_ACCUMULATOR_FAST_EN: 2 per cycle).
// Latency: out_valid 4 cycles after accept (2 with PP_ACCUMULATOR_FAST_EN); one operation in flight at a time.
// Backpressure: DONE holds product/out_valid until out_ready; in_ready only in IDLE.
module pp_accumulator (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [8:0]  pp0,
    input  logic [8:0]  pp1,
    input  logic [8:0]  pp2,
    input  logic [8:0]  pp3,
    input  logic        clr,
    output logic [15:0] product,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t      state, state_nxt;
    logic [8:0]  pp_r [4];
    logic [15:0] acc;
    logic [1:0]  count;
    logic [15:0] step;
    logic        last_step;

`ifdef PP_ACCUMULATOR_FAST_EN
    localparam logic [1:0] COUNT_INC = 2'd2;
    localparam logic [1:0] COUNT_LAST = 2'd2;
`else
    localparam logic [1:0] COUNT_INC = 2'd1;
    localparam logic [1:0] COUNT_LAST = 2'd3;
`endif

    function automatic logic [15:0] weigh(input logic [8:0] p, input logic [1:0] n);
        logic [15:0] ext;
        ext = {{7{p[8]}}, p};
        return ext << {n, 1'b0};
    endfunction

    always_comb begin
        logic [1:0] idx_hi;
        idx_hi = count + 2'd1;
        step   = weigh(pp_r[count], count);
`ifdef PP_ACCUMULATOR_FAST_EN
        step   = step + weigh(pp_r[idx_hi], idx_hi);
`else
        if (idx_hi == 2'd0) step = step + 16'h0000;
`endif
    end

    assign last_step = (count == COUNT_LAST);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign product   = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // clr dominates both the accept and the output handshake
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid)  state_nxt = ACCUM;
                ACCUM:   if (last_step) state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= 16'h0000;
            count <= 2'd0;
            for (int i = 0; i < 4; i++) pp_r[i] <= 9'h000;
        end else if (clr) begin
            acc   <= 16'h0000;
            count <= 2'd0;
        end else if (state == IDLE && in_valid) begin
            acc     <= 16'h0000;
            count   <= 2'd0;
            pp_r[0] <= pp0;
            pp_r[1] <= pp1;
            pp_r[2] <= pp2;
            pp_r[3] <= pp3;
        end else if (state == ACCUM) begin
            acc   <= acc + step;
            count <= last_step ? 2'd0 : count + COUNT_INC;
        end
    end

endmodule

// File: tb/tb_pp_accumulator.sv
// Randomised and directed bench for pp_accumulator against an arithmetic reference model.
module tb_pp_accumulator;

`ifdef PP_ACCUMULATOR_FAST_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [8:0]  pp0 = '0, pp1 = '0, pp2 = '0, pp3 = '0;
    logic        clr = 1'b0;
    logic [15:0] product;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pp_accumulator dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .pp0(pp0), .pp1(pp1), .pp2(pp2), .pp3(pp3), .clr(clr),
        .product(product), .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [8:0] a, b, c, d);
        int s;
        s = int'($signed(a)) + int'($signed(b)) * 4 + int'($signed(c)) * 16 + int'($signed(d)) * 64;
        return s[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        pp0 = 9'($urandom); pp1 = 9'($urandom); pp2 = 9'($urandom); pp3 = 9'($urandom);
    endtask

    // Accept one set, check latency/result, optionally stall the consumer.
    task automatic run_op(input string tag, input logic [8:0] a, b, c, d, input int stall);
        logic [15:0] exp;
        int cyc;
        exp = model(a, b, c, d);
        check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        pp0 = a; pp1 = b; pp2 = c; pp3 = d;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        tick();
        in_valid = 1'b0;
        scramble();
        check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            scramble();
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(LAT));
        check({tag, "_product"}, 32'(product), 32'(exp));
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            tick();
            scramble();
            check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_stall_product"}, 32'(product), 32'(exp));
            check({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
        check({tag, "_retained"}, 32'(product), 32'(exp));
    endtask

    initial begin
        logic [8:0] r0, r1, r2, r3;
        int seen;
        #2;
        check("reset_product", 32'(product), 32'h0);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        #10 rst_n = 1'b1;
        tick();

        run_op("basic", 9'h005, 9'h00A, 9'h000, 9'h000, 0);
        check("basic_value", 32'(product), 32'h002D);
        run_op("signext", 9'h1FB, 9'h000, 9'h000, 9'h000, 0);
        check("signext_value", 32'(product), 32'hFFFB);
        run_op("top_neg", 9'h000, 9'h000, 9'h000, 9'h100, 0);
        check("top_neg_value", 32'(product), 32'hC000);
        run_op("allmax", 9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF, 0);
        check("allmax_value", 32'(product), 32'h54AB);
        run_op("bp", 9'h1AB, 9'h033, 9'h144, 9'h07E, 5);

        // clr beats an accept in IDLE
        in_valid = 1'b1; clr = 1'b1;
        tick();
        in_valid = 1'b0; clr = 1'b0;
        check("clr_vs_accept", 32'(in_ready), 32'd1);

        // abort during the second ACCUM cycle
        pp0 = 9'h011; pp1 = 9'h022; pp2 = 9'h033; pp3 = 9'h044;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_product", 32'(product), 32'h0);
        seen = 0;
        for (int i = 0; i < LAT + 2; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("abort_no_valid", 32'(seen), 32'd0);

        // reset while DONE is stalled
        pp0 = 9'h07F; pp1 = 9'h001; pp2 = 9'h000; pp3 = 9'h000;
        out_ready = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < LAT; i++) tick();
        check("rst_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_product", 32'(product), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < LAT + 2; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("rst_no_valid", 32'(seen), 32'd0);

        for (int n = 0; n < 25; n++) begin
            r0 = 9'($urandom); r1 = 9'($urandom); r2 = 9'($urandom); r3 = 9'($urandom);
            run_op("rand", r0, r1, r2, r3, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
